cpu_test_sequencer: RTL and testbench

//  Synthesizable, parametrised run-and-check controller for RISCVCPU bring-up (sim and FPGA).

---
 rtl/cpu_test_pkg.sv | 29 ++
 rtl/cpu_test_check_table.sv | 30 +++
 rtl/cpu_test_sequencer.sv | 175 +++++++++++++++++
 tb/tb_cpu_test_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_test_pkg.sv
// Shared types for the RISCVCPU run-and-check sequencer: table entry layout and FSM states.
// Entry field widths are fixed here and must match the sequencer XLEN/DM_AW parameters (DM_AW >= 5).
package cpu_test_pkg;

   localparam int CHK_XLEN  = 32;
   localparam int CHK_DM_AW = 8;

   typedef enum logic {
      CHK_REG  = 1'b0,
      CHK_DMEM = 1'b1
   } check_kind_e;

   typedef struct packed {
      logic                 valid;
      check_kind_e          kind;
      logic [CHK_DM_AW-1:0] addr;
      logic [CHK_XLEN-1:0]  data;
   } check_entry_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOLD,
      S_RUN,
      S_CHK_ISSUE,
      S_CHK_CMP,
      S_DONE
   } seq_state_e;

endpackage

// File: rtl/cpu_test_check_table.sv
// Expected-value table: one write port, asynchronous read, synchronous clear of the valid bits.
module cpu_test_check_table
   import cpu_test_pkg::*;
#(
   parameter int NUM_CHECKS = 16,
   parameter int IDX_W      = 4
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  check_entry_t     wentry,
   input  logic [IDX_W-1:0] ridx,
   output check_entry_t     rentry
);

   check_entry_t mem [NUM_CHECKS];

   // Only the valid bits are cleared; stale payload is harmless behind valid=0.
   always_ff @(posedge clock) begin
      if (clear) begin
         for (int i = 0; i < NUM_CHECKS; i++) mem[i].valid <= 1'b0;
      end else if (we && (int'(widx) < NUM_CHECKS)) begin
         mem[widx] <= wentry;
      end
   end

   assign rentry = (int'(ridx) < NUM_CHECKS) ? mem[ridx] : '0;

endmodule

// File: rtl/cpu_test_sequencer.sv
// Run-and-check controller for RISCVCPU bring-up: reset hold, bounded run window, table sweep.
// Define CPU_TEST_SEQ_FAILMASK_EN to add the per-entry fail_mask output.
module cpu_test_sequencer
   import cpu_test_pkg::*;
#(
   parameter int XLEN         = CHK_XLEN,
   parameter int NUM_CHECKS   = 16,
   parameter int DM_AW        = CHK_DM_AW,
   parameter int RESET_CYCLES = 2,
   parameter int RUN_CYCLES   = 500,
   parameter int CYC_W        = 64,
   localparam int IDX_W       = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
   localparam int CNT_W       = $clog2(NUM_CHECKS + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  tbl_we,
   input  logic [IDX_W-1:0]      tbl_idx,
   input  check_entry_t          tbl_entry,
   input  logic                  halt,
   output logic                  cpu_reset,
   output logic [4:0]            rf_raddr,
   input  logic [XLEN-1:0]       rf_rdata,
   output logic [DM_AW-1:0]      dm_raddr,
   input  logic [XLEN-1:0]       dm_rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [CNT_W-1:0]      pass_count,
   output logic [CNT_W-1:0]      fail_count,
   output logic [IDX_W-1:0]      first_fail,
`ifdef CPU_TEST_SEQ_FAILMASK_EN
   output logic [NUM_CHECKS-1:0] fail_mask,
`endif
   output logic [CYC_W-1:0]      cycle_count
);

   localparam int PH_MAX = (RESET_CYCLES > RUN_CYCLES) ? RESET_CYCLES : RUN_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX + 1);

   function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   seq_state_e        state, state_nxt;
   logic [PH_W-1:0]   ph_cnt;
   logic [IDX_W-1:0]  idx;
   check_entry_t      cur;
   logic              seq_clr, ph_clr, run_tick, idx_inc, enter_done;
   logic              vld_p1, match_p1, last, chk_phase, idle_like;

   cpu_test_check_table #(
      .NUM_CHECKS (NUM_CHECKS),
      .IDX_W      (IDX_W)
   ) u_table (
      .clock  (clock),
      .clear  (!reset),
      .we     (tbl_we && idle_like),
      .widx   (tbl_idx),
      .wentry (tbl_entry),
      .ridx   (idx),
      .rentry (cur)
   );

   assign idle_like = (state == S_IDLE) || (state == S_DONE);
   assign chk_phase = (state == S_CHK_ISSUE) || (state == S_CHK_CMP);
   assign busy      = !idle_like;
   assign cpu_reset = !((state == S_RUN) || chk_phase);
   assign last      = (idx == IDX_W'(NUM_CHECKS - 1));

   // Read address is held through CHK_CMP so a registered debug port sees it stable.
   assign rf_raddr = (chk_phase && cur.valid && cur.kind == CHK_REG)  ? cur.addr[4:0] : '0;
   assign dm_raddr = (chk_phase && cur.valid && cur.kind == CHK_DMEM) ? cur.addr      : '0;
   assign match_p1 = (cur.kind == CHK_REG) ? (rf_rdata == cur.data) : (dm_rdata == cur.data);

   always_ff @(posedge clock) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      seq_clr    = 1'b0;
      ph_clr     = 1'b0;
      run_tick   = 1'b0;
      vld_p1     = 1'b0;
      idx_inc    = 1'b0;
      enter_done = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nxt = S_HOLD;
               seq_clr   = 1'b1;
            end
         end
         S_HOLD: begin
            if (ph_cnt == PH_W'(RESET_CYCLES - 1)) begin
               state_nxt = S_RUN;
               ph_clr    = 1'b1;
            end
         end
         S_RUN: begin
            run_tick = 1'b1;
            if (halt || ph_cnt == PH_W'(RUN_CYCLES - 1)) state_nxt = S_CHK_ISSUE;
         end
         S_CHK_ISSUE: begin
            if (cur.valid) begin
               state_nxt = S_CHK_CMP;
            end else begin
               idx_inc = 1'b1;
               if (last) begin
                  state_nxt  = S_DONE;
                  enter_done = 1'b1;
               end
            end
         end
         S_CHK_CMP: begin
            vld_p1  = 1'b1;
            idx_inc = 1'b1;
            if (last) begin
               state_nxt  = S_DONE;
               enter_done = 1'b1;
            end else begin
               state_nxt = S_CHK_ISSUE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Phase, sweep index and run counter
   always_ff @(posedge clock) begin
      if (!reset || seq_clr || ph_clr) ph_cnt <= '0;
      else if (state == S_HOLD || run_tick) ph_cnt <= ph_cnt + 1'b1;

      if (!reset || seq_clr) idx <= '0;
      else if (idx_inc) idx <= last ? '0 : idx + 1'b1;

      if (!reset || seq_clr) cycle_count <= '0;
      else if (run_tick) cycle_count <= sat_inc(cycle_count);
   end

   // Compare stage results
   always_ff @(posedge clock) begin
      if (!reset || seq_clr) begin
         pass_count <= '0;
         fail_count <= '0;
         first_fail <= '0;
         done       <= 1'b0;
         pass       <= 1'b0;
      end else begin
         if (vld_p1) begin
            if (match_p1) begin
               pass_count <= pass_count + 1'b1;
            end else begin
               fail_count <= fail_count + 1'b1;
               if (fail_count == '0) first_fail <= idx;
            end
         end
         if (enter_done) begin
            done <= 1'b1;
            pass <= (fail_count == '0) && !(vld_p1 && !match_p1);
         end
      end
   end

`ifdef CPU_TEST_SEQ_FAILMASK_EN
   always_ff @(posedge clock) begin
      if (!reset || seq_clr) fail_mask <= '0;
      else if (vld_p1 && !match_p1) fail_mask[idx] <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Bench for cpu_test_sequencer: vector table of whole sequences, a scoreboard of expected results,
// a behavioural core model with one-cycle regfile/DMem debug reads, plus reset-abort sequence.
module tb_cpu_test_sequencer;
   import cpu_test_pkg::*;

   logic         clock = 1'b0;
   logic         reset;
   logic         start;
   logic         tbl_we;
   logic [3:0]   tbl_idx;
   check_entry_t tbl_entry;
   logic         halt;
   logic         cpu_reset;
   logic [4:0]   rf_raddr;
   logic [31:0]  rf_rdata;
   logic [7:0]   dm_raddr;
   logic [31:0]  dm_rdata;
   logic         busy, done, pass;
   logic [4:0]   pass_count, fail_count;
   logic [3:0]   first_fail;
   logic [63:0]  cycle_count;
`ifdef CPU_TEST_SEQ_FAILMASK_EN
   logic [15:0]  fail_mask;
`endif

   cpu_test_sequencer dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .tbl_we      (tbl_we),
      .tbl_idx     (tbl_idx),
      .tbl_entry   (tbl_entry),
      .halt        (halt),
      .cpu_reset   (cpu_reset),
      .rf_raddr    (rf_raddr),
      .rf_rdata    (rf_rdata),
      .dm_raddr    (dm_raddr),
      .dm_rdata    (dm_rdata),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .pass_count  (pass_count),
      .fail_count  (fail_count),
      .first_fail  (first_fail),
`ifdef CPU_TEST_SEQ_FAILMASK_EN
      .fail_mask   (fail_mask),
`endif
      .cycle_count (cycle_count)
   );

   always #5 clock = ~clock;

   // Core model: registered debug reads, data one cycle after the address
   logic [31:0] regs [32];
   logic [31:0] dmem [256];
   always @(posedge clock) begin
      rf_rdata <= regs[rf_raddr];
      dm_rdata <= dmem[dm_raddr];
   end

   // mode: 0 load reference table, 1 load empty table, 2 keep table as is
   typedef struct {
      int mode; int bad_x5; int bad_dm; int halt_at; int halt_hold; int start_we; int poke_busy;
      int lat; int pc; int fc; int ff; int cyc; int pas; int mask;
   } vec_t;

   vec_t vecs [11];
   vec_t sb [$];
   int   errors = 0;
   int   checks = 0;
   int   ref_vals [7] = '{5, 3, 8, 2, 15, 100, 115};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic write_entry(input int idx, input int v, input int k, input int addr, input int data);
      tbl_we          = 1'b1;
      tbl_idx         = 4'(idx);
      tbl_entry.valid = v[0];
      tbl_entry.kind  = check_kind_e'(k[0]);
      tbl_entry.addr  = 8'(addr);
      tbl_entry.data  = 32'(data);
      @(negedge clock);
      tbl_we = 1'b0;
   endtask

   task automatic load_table(input int mode);
      for (int i = 0; i < 16; i++) begin
         if (mode == 0 && i < 7)       write_entry(i, 1, 0, i + 1, ref_vals[i]);
         else if (mode == 0 && i == 7) write_entry(7, 1, 1, 0, 15);
         else                          write_entry(i, 0, 0, 0, 0);
      end
   endtask

   task automatic compare_result(input int n, input string tag);
      vec_t e;
      e = sb.pop_front();
      chk({tag, " latency"},     64'(n),           64'(e.lat));
      chk({tag, " pass"},        64'(pass),        64'(e.pas));
      chk({tag, " pass_count"},  64'(pass_count),  64'(e.pc));
      chk({tag, " fail_count"},  64'(fail_count),  64'(e.fc));
      chk({tag, " first_fail"},  64'(first_fail),  64'(e.ff));
      chk({tag, " cycle_count"}, cycle_count,      64'(e.cyc));
      chk({tag, " cpu_reset"},   64'(cpu_reset),   64'd1);
      chk({tag, " busy"},        64'(busy),        64'd0);
`ifdef CPU_TEST_SEQ_FAILMASK_EN
      chk({tag, " fail_mask"},   64'(fail_mask),   64'(e.mask));
`endif
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int n;
      int rk;
      if (v.mode != 2) load_table(v.mode);
      regs[5]  = (v.bad_x5 != 0) ? 32'd14 : 32'd15;
      dmem[0]  = (v.bad_dm != 0) ? 32'd16 : 32'd15;
      sb.push_back(v);
      start = 1'b1;
      if (v.start_we != 0) begin
         tbl_we          = 1'b1;
         tbl_idx         = 4'd8;
         tbl_entry.valid = 1'b1;
         tbl_entry.kind  = CHK_REG;
         tbl_entry.addr  = 8'd8;
         tbl_entry.data  = 32'd77;
      end
      @(negedge clock);
      start  = 1'b0;
      tbl_we = 1'b0;
      n  = 0;
      rk = 0;
      while (!done && n < 2000) begin
         if (!cpu_reset) rk++;
         halt = ((v.halt_at != 0) && (rk == v.halt_at)) || ((v.halt_hold != 0) && (n < 2));
         if (v.poke_busy != 0 && n == 100) begin
            start           = 1'b1;
            tbl_we          = 1'b1;
            tbl_idx         = 4'd0;
            tbl_entry.valid = 1'b1;
            tbl_entry.kind  = CHK_REG;
            tbl_entry.addr  = 8'd1;
            tbl_entry.data  = 32'd999;
         end else begin
            start  = 1'b0;
            tbl_we = 1'b0;
         end
         @(negedge clock);
         n++;
      end
      halt   = 1'b0;
      start  = 1'b0;
      tbl_we = 1'b0;
      if (n >= 2000) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: done not seen within %0d cycles", tag, n);
      end
      compare_result(n, tag);
   endtask

   initial begin
      int n;
      vec_t ve;
      for (int i = 0; i < 32; i++)  regs[i] = 32'd0;
      for (int i = 0; i < 256; i++) dmem[i] = 32'd0;
      for (int i = 0; i < 7; i++)   regs[i + 1] = 32'(ref_vals[i]);
      regs[8] = 32'd77;
      dmem[0] = 32'd15;

      //           mode x5 dm halt hh swe poke  lat  pc fc ff  cyc pass mask
      vecs[0]  = '{0, 0, 0, 0,   0, 0, 0, 526, 8, 0, 0, 500, 1, 'h0000};
      vecs[1]  = '{0, 1, 0, 0,   0, 0, 0, 526, 7, 1, 4, 500, 0, 'h0010};
      vecs[2]  = '{0, 0, 0, 20,  0, 0, 0, 46,  8, 0, 0, 20,  1, 'h0000};
      vecs[3]  = '{1, 0, 0, 0,   0, 0, 0, 518, 0, 0, 0, 500, 1, 'h0000};
      vecs[4]  = '{0, 1, 1, 0,   0, 0, 0, 526, 6, 2, 4, 500, 0, 'h0090};
      vecs[5]  = '{0, 0, 0, 0,   0, 1, 0, 527, 9, 0, 0, 500, 1, 'h0000};
      vecs[6]  = '{0, 0, 0, 0,   0, 0, 1, 526, 8, 0, 0, 500, 1, 'h0000};
      vecs[7]  = '{0, 0, 0, 1,   0, 0, 0, 27,  8, 0, 0, 1,   1, 'h0000};
      vecs[8]  = '{0, 0, 0, 500, 0, 0, 0, 526, 8, 0, 0, 500, 1, 'h0000};
      vecs[9]  = '{0, 0, 0, 0,   1, 0, 0, 526, 8, 0, 0, 500, 1, 'h0000};
      vecs[10] = '{0, 0, 1, 0,   0, 0, 0, 526, 7, 1, 7, 500, 0, 'h0080};

      reset     = 1'b0;
      start     = 1'b0;
      tbl_we    = 1'b0;
      tbl_idx   = '0;
      tbl_entry = '0;
      halt      = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst busy",        64'(busy),        64'd0);
      chk("rst done",        64'(done),        64'd0);
      chk("rst pass",        64'(pass),        64'd0);
      chk("rst cpu_reset",   64'(cpu_reset),   64'd1);
      chk("rst pass_count",  64'(pass_count),  64'd0);
      chk("rst fail_count",  64'(fail_count),  64'd0);
      chk("rst first_fail",  64'(first_fail),  64'd0);
      chk("rst cycle_count", cycle_count,      64'd0);
      chk("rst rf_raddr",    64'(rf_raddr),    64'd0);
      chk("rst dm_raddr",    64'(dm_raddr),    64'd0);
      reset = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Abort with reset while the first entry is in its compare cycle
      load_table(0);
      regs[5] = 32'd15;
      dmem[0] = 32'd15;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      n = 0;
      while (n < 503) begin
         @(negedge clock);
         n++;
      end
      chk("abort rf_raddr in cmp", 64'(rf_raddr),  64'd1);
      chk("abort busy before",     64'(busy),      64'd1);
      chk("abort cpu_reset low",   64'(cpu_reset), 64'd0);
      reset = 1'b0;
      @(negedge clock);
      chk("abort busy",        64'(busy),       64'd0);
      chk("abort done",        64'(done),       64'd0);
      chk("abort cpu_reset",   64'(cpu_reset),  64'd1);
      chk("abort pass_count",  64'(pass_count), 64'd0);
      chk("abort fail_count",  64'(fail_count), 64'd0);
      chk("abort cycle_count", cycle_count,     64'd0);
      chk("abort rf_raddr",    64'(rf_raddr),   64'd0);
      reset = 1'b1;
      @(negedge clock);

      // Table must be empty after the reset: sweep is all 1-cycle skips
      ve = '{2, 0, 0, 0, 0, 0, 0, 518, 0, 0, 0, 500, 1, 'h0000};
      run_vec(ve, "after_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
